// File: rtl/train_ctrl_pkg.sv
// Shared train-controller definitions: FSM states, step indices, counter sizing.
package train_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_ADVANCE,
    ST_FAULT
  } state_e;

  // Step index, shared with the condition synchronizer side.
  typedef logic [3:0] step_t;

  localparam step_t STEP_TIMED_FIRST = 4'd2;
  localparam step_t STEP_TIMED_LAST  = 4'd5;
  localparam step_t STEP_LAST        = 4'd15;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Steps whose condition is the dwell timer.
  function automatic logic is_timed(input step_t s);
    return (s >= STEP_TIMED_FIRST) && (s <= STEP_TIMED_LAST);
  endfunction

endpackage

// File: rtl/train_dwell_timer.sv
// Loadable saturating down-counter with a zero flag. Used for the dwell
// timer and, loaded with its limit, as the per-step watchdog.
module train_dwell_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load wins over counting; counting stops at zero instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  count <= '0;
    else if (load)               count <= load_val;
    else if (en && count != '0)  count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/train_step_sequencer.sv
// Train route step sequencer: walks the 4-bit step index, advancing once per
// debounced condition Y, with a dwell flag on timed steps and a per-step
// watchdog that latches a fault when a step stalls.
module train_step_sequencer
  import train_ctrl_pkg::*;
#(
  parameter int DWELL_CYCLES    = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WATCHDOG_CYCLES = 500_000_000
) (
  input  logic  CLK,
  input  logic  RST_N,
  input  logic  START,
  input  logic  STOP,
  input  logic  Y,
  output step_t Selector,
  output logic  Enable,
  output logic  TIMER,
  output logic  Busy,
  output logic  StepDone,
  output logic  Lap,
  output logic  Fault
);

  localparam int DW = cnt_width(DWELL_CYCLES);
  localparam int BW = cnt_width(DEBOUNCE_CYCLES);
  localparam int WW = cnt_width(WATCHDOG_CYCLES);

  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WW-1:0] WD_LOAD    = WW'(WATCHDOG_CYCLES - 1);

  state_e          state_q, state_d;
  step_t           sel_q;
  logic [BW-1:0]   deb_q;
  logic            in_arm, in_wait;
  logic            dwell_zero, wd_zero;
  logic            advance;

  assign in_arm  = (state_q == ST_ARM);
  assign in_wait = (state_q == ST_WAIT);

  // Dwell: loaded in ARM, so it reaches zero on WAIT clock DWELL_CYCLES.
  train_dwell_timer #(.WIDTH(DW)) u_dwell (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (in_arm),
    .en       (in_wait),
    .load_val (DWELL_LOAD),
    .zero     (dwell_zero)
  );

  // Watchdog counts remaining WAIT clocks; zero means the step has sat in
  // WAIT for WATCHDOG_CYCLES clocks (elapsed count reached the limit).
  train_dwell_timer #(.WIDTH(WW)) u_watchdog (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (in_arm),
    .en       (in_wait),
    .load_val (WD_LOAD),
    .zero     (wd_zero)
  );

  // Accept on the clock that completes DEBOUNCE_CYCLES consecutive highs.
  assign advance = in_wait && Y && (deb_q == DEB_LAST);

  // Debounce: run length of consecutive high Y inside WAIT, saturating.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                   deb_q <= '0;
    else if (!in_wait || !Y)      deb_q <= '0;
    else if (deb_q != DEB_LAST)   deb_q <= deb_q + 1'b1;
  end

  // Step register: moves only on ADVANCE, even if STOP arrives that clock.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                      sel_q <= '0;
    else if (state_q == ST_ADVANCE)  sel_q <= sel_q + 4'd1;
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: STOP dominates, advance beats watchdog expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (START && !STOP) state_d = ST_ARM;
      ST_ARM:     state_d = STOP ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (STOP)         state_d = ST_IDLE;
        else if (advance) state_d = ST_ADVANCE;
        else if (wd_zero) state_d = ST_FAULT;
      end
      ST_ADVANCE: state_d = STOP ? ST_IDLE : ST_ARM;
      ST_FAULT:   if (STOP) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from registered state only (no path from Y).
  always_comb begin
    Enable   = 1'b0;
    Busy     = (state_q != ST_IDLE);
    StepDone = 1'b0;
    Lap      = 1'b0;
    Fault    = 1'b0;
    TIMER    = in_wait && is_timed(sel_q) && dwell_zero;
    unique case (state_q)
      ST_ARM, ST_WAIT: Enable = 1'b1;
      ST_ADVANCE: begin
        Enable   = 1'b1;
        StepDone = 1'b1;
        Lap      = (sel_q == STEP_LAST);
      end
      ST_FAULT:   Fault = 1'b1;
      default:    ;
    endcase
  end

  assign Selector = sel_q;

endmodule

// File: tb/tb_train_step_sequencer.sv
// Bench for train_step_sequencer: randomized Y patterns per step, a step-level
// reference model predicting each StepDone (cycle, selector, lap), and a
// negedge monitor comparing per-cycle status and popping expected events.
module tb_train_step_sequencer;
  import train_ctrl_pkg::*;

  localparam int D  = 8;
  localparam int DB = 3;
  localparam int W  = 32;

  logic  CLK = 1'b0, RST_N = 1'b0, START = 1'b0, STOP = 1'b0;
  logic  y_drv = 1'b0, use_timer = 1'b0;
  logic  Y;
  step_t Selector;
  logic  Enable, TIMER, Busy, StepDone, Lap, Fault;

  assign Y = use_timer ? TIMER : y_drv;

  train_step_sequencer #(
    .DWELL_CYCLES(D), .DEBOUNCE_CYCLES(DB), .WATCHDOG_CYCLES(W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .Y(Y),
    .Selector(Selector), .Enable(Enable), .TIMER(TIMER), .Busy(Busy),
    .StepDone(StepDone), .Lap(Lap), .Fault(Fault)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  typedef struct { int sel; bit lap; int cyc; } ev_t;
  ev_t evq[$];
  ev_t ev;

  // Expected per-cycle status, set by the stimulus for the current cycle.
  int e_sel = 0;
  bit e_en = 0, e_busy = 0, e_tim = 0, e_flt = 0;
  bit mon_en = 0;
  int m_sel = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_exp(input int sel, input bit en, input bit busy, input bit tim, input bit flt);
    e_sel = sel; e_en = en; e_busy = busy; e_tim = tim; e_flt = flt;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  function automatic bit timed(input int s);
    return (s >= 2) && (s <= 5);
  endfunction

  // Monitor: status every cycle, StepDone events against the scoreboard.
  always @(negedge CLK) begin
    if (mon_en) begin
      check("status{sel,en,busy,timer,fault}", {Selector, Enable, Busy, TIMER, Fault},
            {e_sel[3:0], e_en, e_busy, e_tim, e_flt});
      if (evq.size() > 0 && evq[0].cyc < cyc) begin
        checks++; errors++;
        ev = evq.pop_front();
        $display("FAIL stepdone_missing: no pulse, expected at cycle %0d for step %0d", ev.cyc, ev.sel);
      end
      if (StepDone) begin
        if (evq.size() == 0) begin
          checks++; errors++;
          $display("FAIL stepdone_unexpected: pulse at cycle %0d, expected none", cyc);
        end else begin
          ev = evq.pop_front();
          check("stepdone_sel", Selector, ev.sel);
          check("stepdone_lap", Lap, ev.lap);
          check("stepdone_cycle", cyc, ev.cyc);
        end
      end else begin
        check("lap_without_stepdone", Lap, 0);
      end
    end
  end

  // From IDLE: pulse START, land in ARM.
  task automatic do_start();
    START = 1'b1;
    tick();
    START = 1'b0;
    y_drv = 1'($urandom_range(0, 1));
    set_exp(m_sel, 1, 1, 0, 0);
  endtask

  // Entry/exit: in the ARM cycle of step m_sel.
  // mode 0: Y held high, 1: random glitchy prefix, 2: Y = TIMER, 3: 1,1,0,1,1,1
  task automatic run_step(input int mode, input bit stop_adv);
    bit pat[64];
    int k, run, n;
    for (int i = 0; i < 64; i++) pat[i] = 1'b1;
    case (mode)
      1: begin
        n = $urandom_range(0, 15);
        for (int i = 0; i < n; i++) pat[i] = ($urandom_range(0, 99) < 60);
      end
      2: for (int i = 0; i < 64; i++) pat[i] = (i + 1 >= D);
      3: pat[2] = 1'b0;
      default: ;
    endcase
    // Accepted on the DB-th consecutive high WAIT clock.
    k = 0; run = 0;
    for (int i = 0; i < 64 && k == 0; i++) begin
      run = pat[i] ? run + 1 : 0;
      if (run == DB) k = i + 1;
    end
    evq.push_back('{m_sel, (m_sel == 15), cyc + k + 1});
    for (int j = 1; j <= k; j++) begin
      tick();
      use_timer = (mode == 2);
      y_drv = pat[j-1];
      set_exp(m_sel, 1, 1, timed(m_sel) && (j >= D), 0);
    end
    tick();
    use_timer = 1'b0;
    y_drv = 1'($urandom_range(0, 1));
    STOP = stop_adv;
    set_exp(m_sel, 1, 1, 0, 0);
    tick();
    STOP = 1'b0;
    m_sel = (m_sel + 1) % 16;
    if (stop_adv) set_exp(m_sel, 0, 0, 0, 0);
    else          set_exp(m_sel, 1, 1, 0, 0);
  endtask

  task automatic rand_step();
    int mode;
    if (timed(m_sel) && $urandom_range(0, 1) == 1) mode = 2;
    else mode = ($urandom_range(0, 3) == 0) ? 0 : 1;
    run_step(mode, 0);
  endtask

  // Step stalls: Y never has DB consecutive highs, watchdog faults.
  task automatic run_watchdog();
    for (int j = 1; j <= W; j++) begin
      tick();
      y_drv = (j % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      set_exp(m_sel, 1, 1, 0, 0);
    end
    repeat (4) begin
      tick();
      y_drv = 1'($urandom_range(0, 1));
      set_exp(m_sel, 0, 1, 0, 1);
    end
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    set_exp(m_sel, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    set_exp(0, 0, 0, 0, 0);
    mon_en = 1'b1;
    repeat (3) tick();
    RST_N = 1'b1;
    tick();
    // STOP beats START in IDLE.
    START = 1'b1; STOP = 1'b1;
    repeat (3) tick();
    START = 1'b0; STOP = 1'b0;
    tick();

    do_start();
    run_step(0, 0);            // step 0, held high
    run_step(3, 0);            // step 1, debounce glitch pattern
    run_step(2, 0);            // step 2, timed
    while (m_sel != 6) rand_step();
    run_watchdog();            // step 6 faults, STOP to IDLE
    do_start();                // resumes on step 6
    while (m_sel != 10) rand_step();
    run_step(1, 1);            // STOP during ADVANCE: increment still lands
    tick();
    do_start();
    while (m_sel != 15) rand_step();
    run_step(0, 0);            // lap and wrap to 0
    while (m_sel != 9) rand_step();

    // Asynchronous reset in the middle of WAIT on step 9.
    y_drv = 1'b0;
    tick(); set_exp(9, 1, 1, 0, 0);
    tick();
    #2;
    mon_en = 1'b0;
    RST_N = 1'b0;
    #1;
    check("rst_selector", Selector, 0);
    check("rst_enable", Enable, 0);
    check("rst_busy", Busy, 0);
    check("rst_outputs{timer,stepdone,lap,fault}", {TIMER, StepDone, Lap, Fault}, 0);
    m_sel = 0;
    set_exp(0, 0, 0, 0, 0);
    mon_en = 1'b1;
    repeat (2) tick();
    RST_N = 1'b1;
    repeat (2) tick();
    mon_en = 1'b0;
    check("events_left", evq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
